// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter serialising four cores onto one
// single-ported memory bank (combinational read, write on clock edge).
// Each access occupies IDLE(sample) -> GRANT(bank cycle) -> RESP(ack).
module shared_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            req_we,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_wdata,
  output logic [3:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [3:0]            grant,
  output logic                  busy,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_write_data,
  input  logic [DATA_W-1:0]     mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                pick_valid;
  logic [1:0]          pick_idx;
  logic [1:0]          cand;
  logic                in_grant;

  // Round-robin pick: first requesting core scanning upward from rr_ptr, mod 4
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-register values for the arbitration FSM
  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    ack_d    = '0;
    rdata_d  = rdata_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = 4'b0001 << pick_idx;
          win_d   = pick_idx;
          we_d    = req_we[pick_idx];
          addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!we_q) begin
          rdata_d = mem_read_data;
        end
        ack_d    = grant_q;
        rr_ptr_d = win_q + 2'd1;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers; async reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      rr_ptr_q <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Bank port decodes only from registered state and latched operands
  always_comb begin
    in_grant       = (state_q == GRANT);
    mem_write_en   = in_grant & we_q;
    mem_read_en    = in_grant & ~we_q;
    mem_address    = in_grant ? addr_q  : '0;
    mem_write_data = in_grant ? wdata_q : '0;
    busy           = (state_q != IDLE);
    grant          = grant_q;
    ack            = ack_q;
    rdata          = rdata_q;
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Testbench for shared_mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_shared_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          req = '0;
  logic [3:0]          req_we = '0;
  logic [4*ADDR_W-1:0] req_addr = '0;
  logic [4*DATA_W-1:0] req_wdata = '0;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic [3:0]          grant;
  logic                busy;
  logic                mem_read_en;
  logic                mem_write_en;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W-1:0]   mem_write_data;
  logic [DATA_W-1:0]   mem_read_data;

  logic [DATA_W-1:0]   bank [1024];
  logic [DATA_W-1:0]   junk = 32'hBAD0_0000;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ack            (ack),
    .rdata          (rdata),
    .grant          (grant),
    .busy           (busy),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Bank model: combinational read while enabled, garbage otherwise so a late
  // capture of mem_read_data shows up as wrong rdata.
  assign mem_read_data = mem_read_en ? bank[mem_address[11:2]] : junk;

  always @(posedge clk) begin
    if (mem_write_en) bank[mem_address[11:2]] <= mem_write_data;
    junk <= $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    return 4'b0001 << c;
  endfunction

  task automatic set_op(input int c, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    req_we[c] = we;
    req_addr[c*ADDR_W +: ADDR_W] = a;
    req_wdata[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at a negedge where the arbiter is in IDLE (req must already be low)
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Single access by one core from IDLE: grant next cycle, ack the one after
  task automatic access(input int c, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd,
                        input string tag);
    wait_idle();
    set_op(c, we, a, d);
    req[c] = 1'b1;
    @(negedge clk);
    chk({tag, "_grant"}, 64'(grant), 64'(oh(c)));
    chk({tag, "_men"}, 64'({mem_write_en, mem_read_en}), 64'({we, !we}));
    chk({tag, "_maddr"}, 64'(mem_address), 64'(a));
    if (we) chk({tag, "_mwdata"}, 64'(mem_write_data), 64'(d));
    @(negedge clk);
    chk({tag, "_ack"}, 64'(ack), 64'(oh(c)));
    chk({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
    req[c] = 1'b0;
  endtask

  // Hold req=mask (reads) until n accesses complete; order holds 2-bit winners
  task automatic rr_seq(input logic [3:0] mask, input int n, input logic [15:0] order,
                        input string tag);
    int k = 0;
    int cyc = 0;
    int last = 0;
    int ack_seen = 0;
    logic [3:0] exp_a = '0;
    wait_idle();
    for (int c = 0; c < 4; c++) if (mask[c]) set_op(c, 1'b0, 32'h100 + 32'(c * 4), '0);
    req = mask;
    while (ack_seen < n && cyc < 3 * n + 6) begin
      @(negedge clk);
      cyc++;
      chk({tag, "_ack"}, 64'(ack), 64'(exp_a));
      if (exp_a != 0) ack_seen++;
      exp_a = '0;
      if (grant != 0) begin
        if (k < n) begin
          chk({tag, "_grant"}, 64'(grant), 64'(oh(int'(order[2*k +: 2]))));
          if (k == 0) chk({tag, "_latency"}, 64'(cyc), 64'd1);
          else chk({tag, "_gap"}, 64'(cyc - last), 64'd3);
          exp_a = oh(int'(order[2*k +: 2]));
        end else begin
          chk({tag, "_extra_grant"}, 64'(grant), 64'd0);
        end
        last = cyc;
        k++;
      end
      if (ack_seen == n) req = '0;
    end
    if (ack_seen < n) chk({tag, "_timeout"}, 64'(ack_seen), 64'(n));
    req = '0;
  endtask

  // Reference-model state for the random phase
  logic [DATA_W-1:0] ref_mem [16];

  task automatic new_op(input int c);
    logic [ADDR_W-1:0] a;
    a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
    set_op(c, 1'($urandom_range(1)), a, $urandom);
    req[c] = 1'b1;
  endtask

  task automatic random_phase(input int ncyc);
    int m_ph = 0;            // 0: arbiter free, 1: bank cycle, 2: ack cycle
    int m_ptr = 0;
    int m_win = 0;
    logic l_we = 1'b0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [DATA_W-1:0] l_wdata = '0;
    logic [3:0] exp_grant = '0, exp_ack = '0;
    logic exp_busy = 1'b0, exp_mwe = 1'b0, exp_mre = 1'b0;
    logic [ADDR_W-1:0] exp_maddr = '0;
    logic [DATA_W-1:0] exp_mwdata = '0, exp_rdata = '0;
    bit found;
    int c;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bank[i] <= ref_mem[i];
    end
    for (int cy = 0; cy < ncyc; cy++) begin
      @(negedge clk);
      chk("rnd_grant", 64'(grant), 64'(exp_grant));
      chk("rnd_ack", 64'(ack), 64'(exp_ack));
      chk("rnd_busy", 64'(busy), 64'(exp_busy));
      chk("rnd_men", 64'({mem_write_en, mem_read_en}), 64'({exp_mwe, exp_mre}));
      chk("rnd_maddr", 64'(mem_address), 64'(exp_maddr));
      chk("rnd_mwdata", 64'(mem_write_data), 64'(exp_mwdata));
      if (exp_ack != 0) chk("rnd_rdata", 64'(rdata), 64'(exp_rdata));
      // Requesters: hold until ack, then either drop or issue a fresh access
      for (int i = 0; i < 4; i++) begin
        if (exp_ack[i]) begin
          if ($urandom_range(1) == 1) new_op(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3) == 0) begin
          new_op(i);
        end
      end
      // Predict the next cycle from the arbitration rules
      exp_grant = '0; exp_ack = '0; exp_busy = 1'b0;
      exp_mwe = 1'b0; exp_mre = 1'b0; exp_maddr = '0; exp_mwdata = '0;
      if (m_ph == 0) begin
        if (req != 0) begin
          found = 0;
          for (int s = 0; s < 4; s++) begin
            c = (m_ptr + s) % 4;
            if (!found && req[c]) begin
              found = 1;
              m_win = c;
            end
          end
          l_we = req_we[m_win];
          l_addr = req_addr[m_win*ADDR_W +: ADDR_W];
          l_wdata = req_wdata[m_win*DATA_W +: DATA_W];
          exp_grant = oh(m_win);
          exp_busy = 1'b1;
          exp_mwe = l_we;
          exp_mre = !l_we;
          exp_maddr = l_addr;
          exp_mwdata = l_wdata;
          m_ph = 1;
        end
      end else if (m_ph == 1) begin
        exp_ack = oh(m_win);
        exp_busy = 1'b1;
        if (l_we) ref_mem[l_addr[5:2]] = l_wdata;
        else exp_rdata = ref_mem[l_addr[5:2]];
        m_ptr = (m_win + 1) % 4;
        m_ph = 2;
      end else begin
        m_ph = 0;
      end
    end
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bank[i] <= '0;

    // Reset state, including bank port held at zero during reset
    @(negedge clk);
    chk("reset_outs", 64'({grant, ack, busy, mem_read_en, mem_write_en}), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_maddr", 64'(mem_address), 64'd0);
    rst_n = 1'b1;

    // Idle for 20 cycles with no requests
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 64'({busy, grant, ack, mem_read_en, mem_write_en}), 64'd0);
    end

    // Core 2 write then read back
    access(2, 1'b1, 32'h010, 32'hDEAD_BEEF, 32'h0, "wr_c2");
    access(2, 1'b0, 32'h010, 32'h0, 32'hDEAD_BEEF, "rd_c2");

    // Read capture, then a write must leave rdata untouched
    bank[5] <= 32'h1234_5678;
    access(3, 1'b0, 32'h014, 32'h0, 32'h1234_5678, "rd_c3");
    @(negedge clk);
    chk("rd_c3_hold", 64'(rdata), 64'h1234_5678);
    access(0, 1'b1, 32'h020, 32'h0BAD_F00D, 32'h1234_5678, "wr_c0");
    chk("wr_c0_bank", 64'(bank[8]), 64'h0BAD_F00D);

    // rr_ptr=2 (after core 1), req=0011: wrap to core 0, then core 1
    access(1, 1'b0, 32'h020, 32'h0, 32'h0BAD_F00D, "rd_c1");
    rr_seq(4'b0011, 2, 16'h0004, "wrap");

    // All four from reset: 0,1,2,3,0 then pointer sits at 1
    do_reset();
    rr_seq(4'b1111, 5, 16'h00E4, "all4");
    rr_seq(4'b0011, 1, 16'h0001, "ptr1");

    // Async reset in the middle of a core 1 write (pointer is 2 beforehand)
    bank[12] <= 32'h1111_1111;
    wait_idle();
    set_op(1, 1'b1, 32'h030, 32'hAAAA_5555);
    req[1] = 1'b1;
    @(negedge clk);
    chk("rst_grant", 64'({grant, mem_write_en}), 64'({4'b0010, 1'b1}));
    #1 rst_n = 1'b0;
    #1 chk("rst_outs", 64'({mem_write_en, mem_read_en, busy, grant, ack}), 64'd0);
    @(negedge clk);
    chk("rst_bank", 64'(bank[12]), 64'h1111_1111);
    chk("rst_ack", 64'(ack), 64'd0);
    req = '0;
    rst_n = 1'b1;
    rr_seq(4'b1010, 1, 16'h0001, "rst_ptr0");

    random_phase(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
